// File: rtl/spi_pkg.sv
// Shared SPI types: master FSM state encoding, clock-divider floor and adapter packet field positions.
// Pure declarations; no latency or backpressure of its own.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    SCLK_HIGH = 3'd2,
    SCLK_LOW  = 3'd3,
    DONE      = 3'd4
  } spi_master_state_e;

  // Smallest sclk half-period the far-side minion's sclk synchronizer can follow.
  localparam int SPI_MIN_CLK_DIV = 3;

  // Adapter packets carry two flag bits at the top of an nbits-wide word.
  function automatic int mosi_val_wrt_pos(input int nbits);
    return nbits - 1;
  endfunction

  function automatic int mosi_val_rd_pos(input int nbits);
    return nbits - 2;
  endfunction

  function automatic int miso_val_pos(input int nbits);
    return nbits - 1;
  endfunction

  function automatic int miso_spc_pos(input int nbits);
    return nbits - 2;
  endfunction

endpackage

// File: rtl/spi_shift_reg.sv
// Parallel-load shift register: serial in at bit 0, serial out at the MSB.
// Load or shift takes effect on the next clk edge; load wins over shift.
module spi_shift_reg #(
  parameter int NBITS = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [NBITS-1:0] load_dat,
  input  logic             shift,
  input  logic             sin,
  output logic [NBITS-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (load) begin
      q <= load_dat;
    end else if (shift) begin
      q <= {q[NBITS-2:0], sin};
    end
  end

endmodule

// File: rtl/spi_master_adapter.sv
// SPI mode-0 master: one val/rdy request word becomes one MSB-first transfer, and the received word goes out on send.
// Response comes CLK_DIV*(1+2N)+1 cycles after the request fire; no new request is taken until the response fires.
module spi_master_adapter
  import spi_pkg::*;
#(
  parameter int NBITS   = 8,
  parameter int NCS     = 1,
  parameter int CLK_DIV = 4
) (
  input  logic                                   clk,
  input  logic                                   reset,
  output logic [NCS-1:0]                         cs,
  output logic                                   sclk,
  output logic                                   mosi,
  input  logic                                   miso,
  input  logic                                   recv_val,
  output logic                                   recv_rdy,
  input  logic [NBITS-1:0]                       recv_msg,
  output logic                                   send_val,
  input  logic                                   send_rdy,
  output logic [NBITS-1:0]                       send_msg,
  input  logic                                   pkt_size_val,
  output logic                                   pkt_size_rdy,
  input  logic [$clog2(NBITS):0]                 pkt_size_msg,
  input  logic                                   cs_addr_val,
  output logic                                   cs_addr_rdy,
  input  logic [((NCS > 1) ? $clog2(NCS) : 1)-1:0] cs_addr_msg
);

  localparam int PW = $clog2(NBITS) + 1;
  localparam int CW = (NCS > 1) ? $clog2(NCS) : 1;
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [2:0] S_IDLE      = IDLE;
  localparam logic [2:0] S_START     = START;
  localparam logic [2:0] S_SCLK_HIGH = SCLK_HIGH;
  localparam logic [2:0] S_SCLK_LOW  = SCLK_LOW;
  localparam logic [2:0] S_DONE      = DONE;

  // A zero or oversized packet length means a full NBITS transfer.
  function automatic logic [PW-1:0] eff_size(input logic [PW-1:0] v);
    if (v == '0 || int'(v) > NBITS) return PW'(NBITS);
    return v;
  endfunction

  logic [2:0]       state;
  logic [DW-1:0]    div_cnt;
  logic [PW-1:0]    bit_cnt;
  logic [PW-1:0]    pkt_size_q;
  logic [CW-1:0]    cs_addr_q;
  logic [PW-1:0]    n_now;
  logic [NBITS-1:0] load_dat;
  logic [NBITS-1:0] shreg_q;
  logic [NBITS-1:0] all_ones;
  logic [NBITS-1:0] rx_mask;
  logic             idle;
  logic             active;
  logic             div_last;
  logic             recv_fire;
  logic             send_fire;
  logic             pkt_size_fire;
  logic             cs_addr_fire;
  logic             cs_addr_ok;
  logic             shift_en;

  assign idle          = (state == S_IDLE);
  assign active        = (state == S_START) || (state == S_SCLK_HIGH) || (state == S_SCLK_LOW);
  assign div_last      = (div_cnt == DW'(CLK_DIV - 1));
  assign recv_fire     = recv_val && recv_rdy;
  assign send_fire     = send_val && send_rdy;
  assign pkt_size_fire = pkt_size_val && pkt_size_rdy;
  assign cs_addr_fire  = cs_addr_val && cs_addr_rdy;
  assign cs_addr_ok    = ({1'b0, cs_addr_msg} < (CW + 1)'(NCS));

  // Same-cycle config applies to the transfer being launched, so the length comes from the input.
  assign n_now    = pkt_size_fire ? eff_size(pkt_size_msg) : pkt_size_q;
  assign load_dat = recv_msg << (NBITS - int'(n_now));
  assign shift_en = (state == S_SCLK_HIGH) && div_last;

  spi_shift_reg #(.NBITS(NBITS)) u_shreg (
    .clk      (clk),
    .reset    (reset),
    .load     (recv_fire),
    .load_dat (load_dat),
    .shift    (shift_en),
    .sin      (miso),
    .q        (shreg_q)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      div_cnt    <= '0;
      bit_cnt    <= '0;
      pkt_size_q <= PW'(NBITS);
      cs_addr_q  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pkt_size_fire) pkt_size_q <= eff_size(pkt_size_msg);
          if (cs_addr_fire && cs_addr_ok) cs_addr_q <= cs_addr_msg;
          if (recv_fire) begin
            bit_cnt <= '0;
            div_cnt <= '0;
            state   <= S_START;
          end
        end
        S_START, S_SCLK_HIGH: begin
          if (div_last) begin
            div_cnt <= '0;
            state   <= (state == S_START) ? S_SCLK_HIGH : S_SCLK_LOW;
          end else begin
            div_cnt <= div_cnt + DW'(1);
          end
        end
        S_SCLK_LOW: begin
          if (div_last) begin
            div_cnt <= '0;
            bit_cnt <= bit_cnt + PW'(1);
            state   <= (bit_cnt + PW'(1) == pkt_size_q) ? S_DONE : S_SCLK_HIGH;
          end else begin
            div_cnt <= div_cnt + DW'(1);
          end
        end
        S_DONE: begin
          if (send_fire) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    cs = '1;
    if (active) cs[cs_addr_q] = 1'b0;
  end

  assign all_ones     = '1;
  assign rx_mask      = ~(all_ones << pkt_size_q);
  assign sclk         = (state == S_SCLK_HIGH);
  assign mosi         = active && shreg_q[NBITS-1];
  assign recv_rdy     = idle && !reset;
  assign pkt_size_rdy = idle && !reset;
  assign cs_addr_rdy  = idle && !reset;
  assign send_val     = (state == S_DONE);
  assign send_msg     = shreg_q & rx_mask;

endmodule

// File: tb/tb_spi_master_adapter.sv
// Directed bench for spi_master_adapter (NBITS=8, NCS=2, CLK_DIV=3) with loopback and a simple mode-0 minion.
module tb_spi_master_adapter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] cs;
  logic       sclk;
  logic       mosi;
  logic       miso;
  logic       recv_val = 1'b0;
  logic       recv_rdy;
  logic [7:0] recv_msg = 8'h00;
  logic       send_val;
  logic       send_rdy = 1'b0;
  logic [7:0] send_msg;
  logic       pkt_size_val = 1'b0;
  logic       pkt_size_rdy;
  logic [3:0] pkt_size_msg = 4'd0;
  logic       cs_addr_val = 1'b0;
  logic       cs_addr_rdy;
  logic [0:0] cs_addr_msg = 1'b0;

  int checks = 0;
  int errors = 0;

  logic       loop_mode = 1'b1;
  logic [7:0] minion_word = 8'h00;
  logic       minion_bit;
  int         rises = 0;
  int         falls = 0;
  logic [7:0] mosi_cap = 8'h00;

  always #5 clk = ~clk;

  spi_master_adapter #(.NBITS(8), .NCS(2), .CLK_DIV(3)) dut (
    .clk          (clk),
    .reset        (reset),
    .cs           (cs),
    .sclk         (sclk),
    .mosi         (mosi),
    .miso         (miso),
    .recv_val     (recv_val),
    .recv_rdy     (recv_rdy),
    .recv_msg     (recv_msg),
    .send_val     (send_val),
    .send_rdy     (send_rdy),
    .send_msg     (send_msg),
    .pkt_size_val (pkt_size_val),
    .pkt_size_rdy (pkt_size_rdy),
    .pkt_size_msg (pkt_size_msg),
    .cs_addr_val  (cs_addr_val),
    .cs_addr_rdy  (cs_addr_rdy),
    .cs_addr_msg  (cs_addr_msg)
  );

  // Mode-0 minion: MSB presented when selected, next bit after each sclk fall.
  always_comb begin
    minion_bit = 1'b0;
    if (falls >= 0 && falls < 8) minion_bit = minion_word[7 - falls];
  end
  assign miso = loop_mode ? mosi : minion_bit;

  always @(posedge sclk) begin
    rises    = rises + 1;
    mosi_cap = {mosi_cap[6:0], mosi};
  end
  always @(negedge sclk) falls = falls + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic xfer(input logic [7:0] msg, input logic ps_v, input logic [3:0] ps,
                      input logic ca_v, input logic ca, input logic [1:0] exp_cs, input int hold,
                      output logic [7:0] got, output int lat, output int cslow,
                      output int csbad, output int holdbad);
    int n;
    rises = 0;
    falls = 0;
    mosi_cap = 8'h00;
    recv_val = 1'b1;
    recv_msg = msg;
    pkt_size_val = ps_v;
    pkt_size_msg = ps;
    cs_addr_val = ca_v;
    cs_addr_msg = ca;
    tick();
    recv_val = 1'b0;
    pkt_size_val = 1'b0;
    cs_addr_val = 1'b0;
    n = 0;
    cslow = 0;
    csbad = 0;
    while (send_val !== 1'b1 && n < 300) begin
      if (cs !== 2'b11) begin
        cslow++;
        if (cs !== exp_cs) csbad++;
      end
      tick();
      n++;
    end
    lat = n + 1;
    got = send_msg;
    holdbad = 0;
    for (int i = 0; i < hold; i++) begin
      if (send_val !== 1'b1 || send_msg !== got || recv_rdy !== 1'b0 ||
          cs !== 2'b11 || sclk !== 1'b0) holdbad++;
      tick();
    end
    send_rdy = 1'b1;
    tick();
    send_rdy = 1'b0;
  endtask

  initial begin
    logic [7:0] got;
    int lat, cslow, csbad, holdbad, n;

    tick();
    tick();
    check("rst_cs", cs, 2'b11);
    check("rst_sclk", sclk, 1'b0);
    check("rst_mosi", mosi, 1'b0);
    check("rst_recv_rdy", recv_rdy, 1'b0);
    check("rst_send_val", send_val, 1'b0);
    check("rst_cfg_rdy", {pkt_size_rdy, cs_addr_rdy}, 2'b00);
    reset = 1'b0;
    tick();
    check("idle_rdys", {recv_rdy, pkt_size_rdy, cs_addr_rdy}, 3'b111);

    loop_mode = 1'b1;
    xfer(8'hA5, 1'b0, 4'd0, 1'b0, 1'b0, 2'b10, 0, got, lat, cslow, csbad, holdbad);
    check("t1_msg", got, 8'hA5);
    check("t1_mosi", mosi_cap, 8'hA5);
    check("t1_latency", lat, 52);
    check("t1_cs_low", cslow, 51);
    check("t1_cs_sel", csbad, 0);
    check("t1_rises", rises, 8);
    check("t1_after", send_val, 1'b0);

    loop_mode = 1'b0;
    minion_word = 8'h3C;
    xfer(8'hC3, 1'b0, 4'd0, 1'b0, 1'b0, 2'b10, 0, got, lat, cslow, csbad, holdbad);
    check("t2_msg", got, 8'h3C);
    check("t2_mosi", mosi_cap, 8'hC3);
    check("t2_rises", rises, 8);

    loop_mode = 1'b1;
    xfer(8'h0B, 1'b1, 4'd4, 1'b0, 1'b0, 2'b10, 0, got, lat, cslow, csbad, holdbad);
    check("t3_msg", got, 8'h0B);
    check("t3_mosi", mosi_cap[3:0], 4'b1011);
    check("t3_rises", rises, 4);
    check("t3_latency", lat, 28);
    check("t3_cs_low", cslow, 27);
    xfer(8'h5A, 1'b1, 4'd0, 1'b0, 1'b0, 2'b10, 0, got, lat, cslow, csbad, holdbad);
    check("t3_size0_msg", got, 8'h5A);
    check("t3_size0_rises", rises, 8);

    xfer(8'h96, 1'b0, 4'd0, 1'b1, 1'b1, 2'b01, 0, got, lat, cslow, csbad, holdbad);
    check("t4_cs_sel", csbad, 0);
    check("t4_cs_low", cslow, 51);
    check("t4_msg", got, 8'h96);
    check("t4_cs_idle", cs, 2'b11);
    xfer(8'h69, 1'b0, 4'd0, 1'b0, 1'b0, 2'b01, 0, got, lat, cslow, csbad, holdbad);
    check("t4_keep_sel", csbad, 0);
    check("t4_keep_low", cslow, 51);
    cs_addr_val = 1'b1;
    cs_addr_msg = 1'b0;
    tick();
    cs_addr_val = 1'b0;
    xfer(8'h3E, 1'b0, 4'd0, 1'b0, 1'b0, 2'b10, 0, got, lat, cslow, csbad, holdbad);
    check("t4_back0_sel", csbad, 0);
    check("t4_back0_low", cslow, 51);

    xfer(8'hE7, 1'b0, 4'd0, 1'b0, 1'b0, 2'b10, 10, got, lat, cslow, csbad, holdbad);
    check("t5_msg", got, 8'hE7);
    check("t5_hold", holdbad, 0);

    rises = 0;
    falls = 0;
    recv_val = 1'b1;
    recv_msg = 8'hFF;
    pkt_size_val = 1'b1;
    pkt_size_msg = 4'd4;
    tick();
    recv_val = 1'b0;
    pkt_size_val = 1'b0;
    n = 0;
    while (rises < 3 && n < 200) begin
      tick();
      n++;
    end
    check("t6_reach_bit3", rises, 3);
    reset = 1'b1;
    tick();
    check("t6_rst_cs", cs, 2'b11);
    check("t6_rst_sclk", sclk, 1'b0);
    check("t6_rst_send_val", send_val, 1'b0);
    reset = 1'b0;
    tick();
    check("t6_recv_rdy", recv_rdy, 1'b1);
    xfer(8'hA5, 1'b0, 4'd0, 1'b0, 1'b0, 2'b10, 0, got, lat, cslow, csbad, holdbad);
    check("t6_size_rises", rises, 8);
    check("t6_msg", got, 8'hA5);
    check("t6_latency", lat, 52);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
